// File: rtl/ram_stim_pkg.sv
// Shared state, pattern-mode and LFSR definitions for the RAM exerciser.
package ram_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WR,
        RD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_WALK = 2'd1,
        MODE_INV  = 2'd2,
        MODE_LFSR = 2'd3
    } mode_t;

    // Galois right-shift masks; bit k-1 set for each x^k term of the polynomial.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            3:       return 64'h6;
            4:       return 64'hC;
            5:       return 64'h14;
            6:       return 64'h30;
            7:       return 64'h60;
            8:       return 64'hB8;
            16:      return 64'hB400;
            default: return 64'h1 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/ram_stim_gen_if.sv
// RAM-side bus of the exerciser: clear, write strobe, address, write data and read data.
interface ram_stim_gen_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              aclr;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;

    modport master (output aclr, wren, addr, data, input q);
    modport slave  (input aclr, wren, addr, data, output q);
endinterface

// File: rtl/ram_pat_gen.sv
// Pattern generator shared by the write and read sweeps; load restarts the sequence.
module ram_pat_gen
    import ram_stim_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DATA_SEED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  mode_t             mode,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] TAPS      = DATA_W'(lfsr_taps(DATA_W));
    localparam logic [DATA_W-1:0] SEED      = DATA_W'(DATA_SEED);
    localparam logic [DATA_W-1:0] LFSR_SEED = (SEED == '0) ? DATA_W'(1) : SEED;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_inv;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_init;
    logic [DATA_W-1:0] acc_next;

    always_comb begin
        acc_init = SEED;
        acc_next = acc + DATA_W'(1);
        case (mode)
            MODE_WALK: begin
                acc_init = DATA_W'(1);
                acc_next = {acc[DATA_W-2:0], acc[DATA_W-1]};
            end
            MODE_LFSR: begin
                acc_init = LFSR_SEED;
                acc_next = (acc >> 1) ^ (acc[0] ? TAPS : '0);
            end
            default: ;
        endcase
    end

    // Invert at address width first so widening to DATA_W zero-fills.
    assign idx_inv = ~idx;
    assign value   = (mode == MODE_INV) ? DATA_W'(idx_inv) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
        end else if (load) begin
            idx <= '0;
            acc <= acc_init;
        end else if (step) begin
            idx <= idx + ADDR_W'(1);
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/ram_stim_gen.sv
// RAM exerciser: clear, pattern write sweep, readback compare with saturating error count.
module ram_stim_gen
    import ram_stim_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_MAX  = 10,
    parameter int unsigned DIV       = 3,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned DATA_SEED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    ram_stim_gen_if.master        ram,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       err_cnt,
    output logic                  pass
);

    localparam int unsigned ERR_W = ADDR_W + 1;
    // Never sample q before the RAM can have answered, even if DIV is set too low.
    localparam int unsigned DIV_EFF = (DIV > RD_LAT) ? DIV : RD_LAT + 1;
    localparam int unsigned CNT_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

    state_t            state_q, state_d;
    mode_t             mode_q;
    logic [CNT_W-1:0]  div_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] pat_value;
    logic              pat_load, pat_step;
    logic              tick, last, mismatch;

    assign tick     = (div_cnt == CNT_W'(DIV_EFF - 1));
    assign last     = (addr_q == ADDR_W'(ADDR_MAX));
    assign mismatch = (ram.q != pat_value);
    assign busy     = (state_q != IDLE);
    assign ram.addr = addr_q;
    assign ram.data = ram.wren ? pat_value : '0;

    ram_pat_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DATA_SEED (DATA_SEED)
    ) u_pat (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pat_load),
        .step  (pat_step),
        .mode  (mode_q),
        .value (pat_value)
    );

    always_comb begin
        state_d  = state_q;
        ram.aclr = 1'b0;
        ram.wren = 1'b0;
        done     = 1'b0;
        pat_load = 1'b0;
        pat_step = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = CLR;
            CLR: begin
                ram.aclr = 1'b1;
                pat_load = 1'b1;
                state_d  = WR;
            end
            WR: begin
                ram.wren = 1'b1;
                if (tick) begin
                    if (last) begin
                        state_d  = RD;
                        pat_load = 1'b1;
                    end else begin
                        pat_step = 1'b1;
                    end
                end
            end
            RD: begin
                if (tick) begin
                    if (last) state_d = DONE;
                    else      pat_step = 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_INC;
            div_cnt <= '0;
            addr_q  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || tick || !(state_q inside {WR, RD}))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode_t'(mode);
                        err_cnt <= '0;
                        pass    <= 1'b0;
                    end
                end
                CLR: addr_q <= '0;
                WR: if (tick) addr_q <= last ? '0 : addr_q + ADDR_W'(1);
                RD: begin
                    if (tick) begin
                        if (mismatch && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        addr_q <= last ? '0 : addr_q + ADDR_W'(1);
                    end
                end
                DONE: pass <= (err_cnt == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stim_gen.sv
// Bench for ram_stim_gen: cycle-schedule model for the main instance, LFSR/seed checks on a seed-0 instance.
module tb_ram_stim_gen;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int AMAX = 10;
    localparam int DIV  = 3;
    localparam int RD0  = 2 + (AMAX + 1) * DIV;
    localparam int LAST = RD0 + (AMAX + 1) * DIV;

    localparam logic [7:0] LFSR_TAB [0:10] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3,
                                               8'hE1, 8'hC8, 8'h64, 8'h32, 8'h19};
    localparam logic [7:0] WALK_TAB [0:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                               8'h40, 8'h80, 8'h01, 8'h02, 8'h04};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_start = 1'b0;
    logic          b_start = 1'b0;
    logic [1:0]    a_mode = 2'd0;
    logic          a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [AW:0]   a_err, b_err;
    int            fault_a = 0;
    bit            chk_en = 1'b0;
    int            n_chk = 0;
    int            n_err = 0;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] wr_log [0:15];
    logic [DW-1:0] b_log [0:15];

    ram_stim_gen_if #(.ADDR_W(AW), .DATA_W(DW)) ram_a ();
    ram_stim_gen_if #(.ADDR_W(AW), .DATA_W(DW)) ram_b ();

    ram_stim_gen #(.ADDR_W(AW), .DATA_W(DW), .ADDR_MAX(AMAX), .DIV(DIV), .RD_LAT(1), .DATA_SEED(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .ram(ram_a),
        .busy(a_busy), .done(a_done), .err_cnt(a_err), .pass(a_pass));

    ram_stim_gen #(.ADDR_W(AW), .DATA_W(DW), .ADDR_MAX(AMAX), .DIV(DIV), .RD_LAT(1), .DATA_SEED(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(2'd3), .ram(ram_b),
        .busy(b_busy), .done(b_done), .err_cnt(b_err), .pass(b_pass));

    always #5 clk = ~clk;

    // Registered-read RAM; fault 1 flips bit 0 on reads of address 5.
    always @(posedge clk) begin
        if (ram_a.aclr) begin
            for (int i = 0; i < (1 << AW); i++) mem_a[i] <= '0;
        end else if (ram_a.wren) begin
            mem_a[ram_a.addr] <= ram_a.data;
        end
        ram_a.q <= (fault_a == 1 && ram_a.addr == 8'd5) ? (mem_a[ram_a.addr] ^ 8'h01) : mem_a[ram_a.addr];
    end

    assign ram_b.q = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input logic [1:0] m, input int n);
        logic [7:0] nb;
        nb = 8'(n);
        case (m)
            2'd0:    return 8'(1 + n);
            2'd1:    return 8'h01 << (n % 8);
            2'd2:    return ~nb;
            default: return LFSR_TAB[n];
        endcase
    endfunction

    function automatic logic [7:0] readback(input int a, input logic [7:0] v);
        return (fault_a == 1 && a == 5) ? (v ^ 8'h01) : v;
    endfunction

    // Model: m_c is the cycle index within a run (0 = idle, 1 = clear, LAST = done).
    int         m_c = 0;
    logic [1:0] m_mode = 2'd0;
    int         m_err = 0;
    bit         m_pass = 1'b0;
    int         m_a;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_c = 0;
            m_err = 0;
            m_pass = 1'b0;
        end else if (m_c == 0) begin
            if (a_start) begin
                m_c = 1;
                m_mode = a_mode;
                m_err = 0;
                m_pass = 1'b0;
            end
        end else begin
            if (m_c >= RD0 && (m_c - RD0) % DIV == DIV - 1) begin
                m_a = (m_c - RD0) / DIV;
                if (readback(m_a, pat(m_mode, m_a)) != pat(m_mode, m_a) && m_err < 511) m_err++;
            end
            if (m_c == LAST) begin
                m_pass = (m_err == 0);
                m_c = 0;
            end else begin
                m_c++;
            end
        end
    end

    bit e_wren;
    int e_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            e_wren = (m_c >= 2 && m_c < RD0);
            check("aclr", ram_a.aclr, m_c == 1);
            check("wren", ram_a.wren, e_wren);
            check("busy", a_busy, m_c != 0);
            check("done", a_done, m_c == LAST);
            check("err_cnt", a_err, m_err);
            check("pass", a_pass, m_pass);
            if (e_wren) begin
                e_addr = (m_c - 2) / DIV;
                check("wr_addr", ram_a.addr, e_addr);
                check("wr_data", ram_a.data, pat(m_mode, e_addr));
            end else if (m_c >= RD0 && m_c < LAST) begin
                check("rd_addr", ram_a.addr, (m_c - RD0) / DIV);
            end
            if (ram_a.wren === 1'b1 && ram_a.addr < 16) wr_log[ram_a.addr] = ram_a.data;
            if (ram_b.wren === 1'b1) begin
                if (ram_b.addr <= 8'd10) begin
                    check("b_wr_data", ram_b.data, LFSR_TAB[ram_b.addr]);
                    b_log[ram_b.addr] = ram_b.data;
                end else begin
                    check("b_wr_addr", ram_b.addr, 10);
                end
            end
        end
    end

    task automatic launch(input logic [1:0] m, input int f);
        a_mode = m;
        fault_a = f;
        for (int i = 0; i < 16; i++) wr_log[i] = 'x;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int c0, output int cyc);
        cyc = c0;
        while (a_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAST);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_aclr", ram_a.aclr, 0);
        check("rst_wren", ram_a.wren, 0);
        check("rst_addr", ram_a.addr, 0);
        check("rst_data", ram_a.data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_err", a_err, 0);
        check("rst_pass", a_pass, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0 clean, with the seed-0 LFSR instance running alongside against a stuck-at-0 RAM.
        for (int i = 0; i < 16; i++) b_log[i] = 'x;
        b_start = 1'b1;
        launch(2'd0, 0);
        b_start = 1'b0;
        check("aclr_c1", ram_a.aclr, 1);
        wait_done("m0", 1, cyc);
        check("b_done", b_done, 1);
        @(negedge clk);
        check("m0_err", a_err, 0);
        check("m0_pass", a_pass, 1);
        for (int i = 0; i <= AMAX; i++) check("m0_log", wr_log[i], i + 1);
        check("b_first", b_log[0], 8'h01);
        check("b_last", b_log[10], 8'h19);
        check("b_err", b_err, 11);
        check("b_pass", b_pass, 0);

        // Mode 0 with a flipped bit at address 5.
        launch(2'd0, 1);
        wait_done("flip", 1, cyc);
        @(negedge clk);
        check("flip_err", a_err, 1);
        check("flip_pass", a_pass, 0);

        launch(2'd1, 0);
        wait_done("walk", 1, cyc);
        @(negedge clk);
        for (int i = 0; i <= AMAX; i++) check("walk_log", wr_log[i], WALK_TAB[i]);
        check("walk_pass", a_pass, 1);

        launch(2'd2, 0);
        wait_done("inv", 1, cyc);
        @(negedge clk);
        check("inv_first", wr_log[0], 8'hFF);
        check("inv_last", wr_log[10], 8'hF5);
        check("inv_pass", a_pass, 1);

        // Reset mid-write, then a clean run.
        launch(2'd0, 0);
        cyc = 1;
        while (!(ram_a.wren === 1'b1 && ram_a.addr == 8'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_wr4", ram_a.addr, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_wren", ram_a.wren, 0);
        check("mid_rst_aclr", ram_a.aclr, 0);
        check("mid_rst_addr", ram_a.addr, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_err", a_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        launch(2'd0, 0);
        check("post_rst_aclr", ram_a.aclr, 1);
        wait_done("post_rst", 1, cyc);
        @(negedge clk);
        check("post_rst_pass", a_pass, 1);

        // start pulsed mid-read is ignored; start held through DONE restarts right after IDLE.
        launch(2'd0, 0);
        cyc = 1;
        repeat (39) begin
            @(negedge clk);
            cyc++;
        end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc++;
        repeat (25) begin
            @(negedge clk);
            cyc++;
        end
        a_start = 1'b1;
        wait_done("held", cyc, cyc);
        @(negedge clk);
        check("held_idle_busy", a_busy, 0);
        check("held_idle_pass", a_pass, 1);
        @(negedge clk);
        check("restart_aclr", ram_a.aclr, 1);
        a_start = 1'b0;
        wait_done("restart", 1, cyc);
        @(negedge clk);
        check("restart_pass", a_pass, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_stim_gen.md
Name: ram_stim_gen

Overview:
Parametrised RAM exerciser: clears a single-port RAM, writes a pattern sweep over addresses 0..ADDR_MAX, then reads the sweep back and checks it against the regenerated pattern. It replaces the fixed 8-bit, divide-by-3, toggle-write generator. It adds selectable data patterns, a start/done handshake and a readback checker with error count. It sits beside the RAM instance in the lab top level; q is driven by the RAM output.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
ADDR_MAX, 10, last address of the sweep; must be <= 2^ADDR_W-1
DIV, 3, clock cycles per address step; must be >= RD_LAT+1 and >= 1
RD_LAT, 1, RAM read latency in cycles (documentation/check only)
DATA_SEED, 1, first pattern value for modes 0 and 3

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  level; sampled only in IDLE
mode  in  2  pattern select; latched when start is accepted
q  in  DATA_W  RAM read data
aclr  out  1  RAM clear, one-cycle pulse
wren  out  1  RAM write enable
addr  out  ADDR_W  RAM address
data  out  DATA_W  RAM write data
busy  out  1  high from start acceptance until the DONE state is left
done  out  1  one-cycle pulse at end of run
err_cnt  out  ADDR_W+1  readback mismatches, saturating
pass  out  1  err_cnt==0 at end of run; held until next start

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; aclr=0, wren=0, addr=0, data=0, busy=0, done=0, err_cnt=0, pass=0; divider=0. Applies in any state, mid-run included.
- Divider: counts 0..DIV-1 in CLR/WR/RD; tick = (count==DIV-1); reset to 0 on every state entry.
- IDLE: all strobes 0. If start=1: latch mode, err_cnt<=0, pass<=0, go to CLR.
- CLR: aclr=1 for exactly 1 cycle. Then go to WR with addr=0, pattern generator loaded (value index 0).
- WR: wren=1, data=pattern(addr index).
  - On tick with addr<ADDR_MAX: addr+1, pattern steps.
  - On tick with addr==ADDR_MAX: go to RD, addr=0, wren=0, pattern reloaded.
- RD: wren=0, addr held for DIV cycles. On the tick cycle, compare q against the expected pattern value. On mismatch, err_cnt+1, saturating at all-ones.
  - On tick with addr==ADDR_MAX: go to DONE after the final compare.
- DONE: 1 cycle; done=1; pass<=(final err_cnt==0); then IDLE. busy drops on IDLE entry.
- start is ignored outside IDLE. If start is still high on return to IDLE, a new run begins on the next cycle.
- Patterns, with n = sweep index:
  - mode 0: DATA_SEED+n, mod 2^DATA_W.
  - mode 1: walking one, 1<<(n mod DATA_W).
  - mode 2: bitwise inverse of n, zero-extended or truncated to DATA_W.
  - mode 3: Galois LFSR, DATA_W bits, taps from package, starting at DATA_SEED. A seed of 0 is replaced by 1.
- Write and read phases regenerate an identical sequence from reload.
- Run length = 1 + 2*(ADDR_MAX+1)*DIV + 1 cycles after start acceptance.

Decomposition:
- Package ram_stim_pkg:
  - state enum IDLE/CLR/WR/RD/DONE.
  - mode encodings MODE_INC=0, MODE_WALK=1, MODE_INV=2, MODE_LFSR=3.
  - LFSR tap function/constants per DATA_W (8: x^8+x^6+x^5+x^4+1).
- Sub-module ram_pat_gen (clk, rst_n, load, step, mode, value). Holds the index/LFSR register and is instantiated once, shared by the write and read phases.

Test Plan:
- Defaults, mode 0, ideal RAM model (RD_LAT=1) -> aclr pulse 1 cycle after start; writes addr 0..10 with data 1..11, each held 3 cycles; done pulses 68 cycles after start accepted; err_cnt=0, pass=1.
- Mode 0, RAM model flips bit 0 at addr 5 -> err_cnt=1, pass=0; all other compares clean.
- Mode 1, DATA_W=8 -> write data sequence 01,02,04,08,10,20,40,80,01,02,04; pass=1.
- rst_n=0 for one cycle while in WR at addr=4 -> next cycle wren=0, aclr=0, addr=0, busy=0, err_cnt=0. A following start re-enters CLR and completes with pass=1.
- start pulsed during RD, then held high through DONE -> mid-run pulse has no effect; second run starts the cycle after IDLE entry with aclr pulse.
- Mode 3, DATA_SEED=0 -> first written value 01, sequence matches package LFSR reference; RAM stuck at 00 -> err_cnt=11, pass=0.
